fsm_job_arbiter: RTL and testbench

Shares a single `FSM` sequencing unit between two requesters. The block arbitrates requests round-robin and restarts the FSM with a one-cycle kick. It then drives the unit's `en`/`ls`/`rs` inputs from the granted requester's sensor lines and watches `finish`/`stop`. It reports completion or timeout per requester, and sits between the requester logic and the `FSM` instance in `top`.

---
 rtl/fsm_job_arbiter.sv | 139 +++++++++++++
 tb/tb_fsm_job_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_job_arbiter.sv
// Round-robin sharing of one FSM sequencing unit between two requesters:
// grant, one-cycle restart kick, sensor steering, finish/timeout reporting.
module fsm_job_arbiter #(
    parameter int TIMEOUT = 200,
    parameter int TW      = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic [1:0] req_ls_i,
    input  logic [1:0] req_rs_i,
    output logic [1:0] gnt_o,
    output logic [1:0] done_o,
    output logic [1:0] tout_o,
    output logic [7:0] stop_cnt_o,
    output logic       fsm_rst_o,
    output logic       fsm_en_o,
    output logic       fsm_ls_o,
    output logic       fsm_rs_o,
    input  logic       fsm_stop_i,
    input  logic       fsm_busy_i,
    input  logic       fsm_finish_i,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KICK = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    // Handshake: req_i is a level held by the requester until it sees its
    // done_o/tout_o pulse; dropping req_i of the granted side during RUN aborts.
    state_t        state_q, state_d;
    logic          w_q, w_d;
    logic          last_q, last_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    tout_q, tout_d;
    logic [7:0]    stop_q, stop_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          fsm_rst_q, fsm_rst_d;
    logic          pick;
    logic          unused_busy;

    assign unused_busy = fsm_busy_i;

    // With both requesting, the side that was not served last wins.
    assign pick = (req_i == 2'b11) ? ~last_q : req_i[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            w_q       <= 1'b0;
            last_q    <= 1'b1;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            tout_q    <= 2'b00;
            stop_q    <= 8'd0;
            timer_q   <= '0;
            fsm_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            tout_q    <= tout_d;
            stop_q    <= stop_d;
            timer_q   <= timer_d;
            fsm_rst_q <= fsm_rst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        done_d    = 2'b00;
        tout_d    = 2'b00;
        stop_d    = stop_q;
        timer_d   = timer_q;
        fsm_rst_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i != 2'b00) begin
                    w_d       = pick;
                    gnt_d     = pick ? 2'b10 : 2'b01;
                    fsm_rst_d = 1'b1;
                    state_d   = KICK;
                end
            end
            KICK: begin
                timer_d = '0;
                stop_d  = 8'd0;
                state_d = RUN;
            end
            RUN: begin
                timer_d = timer_q + 1'b1;
                if (fsm_stop_i && (stop_q != 8'hFF)) begin
                    stop_d = stop_q + 8'd1;
                end
                // Finish beats abort, abort beats timeout.
                if (fsm_finish_i) begin
                    done_d[w_q] = 1'b1;
                    state_d     = DONE;
                end else if (!req_i[w_q]) begin
                    gnt_d   = 2'b00;
                    last_d  = w_q;
                    state_d = IDLE;
                end else if (timer_q == TIMEOUT_C) begin
                    tout_d[w_q] = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                last_d  = w_q;
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_o      = gnt_q;
    assign done_o     = done_q;
    assign tout_o     = tout_q;
    assign stop_cnt_o = stop_q;
    assign fsm_rst_o  = fsm_rst_q;
    assign fsm_en_o   = (state_q == RUN);
    assign fsm_ls_o   = (state_q == RUN) & req_ls_i[w_q];
    assign fsm_rs_o   = (state_q == RUN) & req_rs_i[w_q];
    assign state_o    = state_q;

endmodule

// File: tb/tb_fsm_job_arbiter.sv
// Directed bench for fsm_job_arbiter: a job-level reference model checked on
// every falling edge, plus literal expectations for the scenarios of interest.
module tb_fsm_job_arbiter;

  localparam int TIMEOUT = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] req_ls = 2'b00;
  logic [1:0] req_rs = 2'b00;
  logic       fsm_stop = 1'b0;
  logic       fsm_busy = 1'b0;
  logic       fsm_finish = 1'b0;
  logic [1:0] gnt, done, tout, state;
  logic [7:0] stop_cnt;
  logic       fsm_rst, fsm_en, fsm_ls, fsm_rs;

  fsm_job_arbiter #(.TIMEOUT(TIMEOUT), .TW(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_ls_i(req_ls), .req_rs_i(req_rs),
    .gnt_o(gnt), .done_o(done), .tout_o(tout), .stop_cnt_o(stop_cnt),
    .fsm_rst_o(fsm_rst), .fsm_en_o(fsm_en), .fsm_ls_o(fsm_ls), .fsm_rs_o(fsm_rs),
    .fsm_stop_i(fsm_stop), .fsm_busy_i(fsm_busy), .fsm_finish_i(fsm_finish),
    .state_o(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Job-level model: owner of the unit, age of the job (0 = restart cycle,
  // k>=1 = run cycle k-1), and whether the job is in its reporting cycle.
  int m_owner = -1;
  int m_age = 0;
  int m_post = 0;
  int m_last = 1;
  int m_stops = 0;
  bit m_fresh = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_age = 0; m_post = 0; m_last = 1; m_stops = 0; m_fresh = 1'b1;
    end else begin
      m_fresh = 1'b0;
      if (m_owner < 0) begin
        if (req != 2'b00) begin
          m_owner = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
          m_age = 0;
          m_post = 0;
        end
      end else if (m_post != 0) begin
        m_last = m_owner;
        m_owner = -1;
        m_post = 0;
      end else if (m_age == 0) begin
        m_age = 1;
        m_stops = 0;
      end else begin
        if (fsm_stop && m_stops < 255) m_stops = m_stops + 1;
        if (fsm_finish) m_post = 1;
        else if (!req[m_owner]) begin
          m_last = m_owner;
          m_owner = -1;
        end else if (m_age - 1 == TIMEOUT) m_post = 2;
        else m_age = m_age + 1;
      end
    end
  end

  // scoreboard: expected grant order plus per-bit pulse counters
  logic [1:0] exp_q[$];
  logic [1:0] got_gnt[$];
  logic [1:0] prev_gnt = 2'b00;
  int run_cnt = 0;
  int last_run_len = 0;
  int done_cnt0 = 0, done_cnt1 = 0, tout_cnt0 = 0, tout_cnt1 = 0;

  always @(negedge clk) begin
    logic [1:0] e_oh;
    bit e_run;
    e_oh = (m_owner >= 0) ? (2'b01 << m_owner) : 2'b00;
    e_run = (m_owner >= 0) && (m_age >= 1) && (m_post == 0);
    check("gnt", gnt, e_oh);
    check("done", done, (m_post == 1) ? e_oh : 2'b00);
    check("tout", tout, (m_post == 2) ? e_oh : 2'b00);
    check("stop_cnt", stop_cnt, m_stops);
    check("fsm_rst", fsm_rst, m_fresh || (m_owner >= 0 && m_age == 0));
    check("fsm_en", fsm_en, e_run);
    check("fsm_ls", fsm_ls, e_run ? req_ls[m_owner] : 1'b0);
    check("fsm_rs", fsm_rs, e_run ? req_rs[m_owner] : 1'b0);
    if (gnt != 2'b00 && prev_gnt == 2'b00) begin
      got_gnt.push_back(gnt);
      run_cnt = 0;
    end
    if (fsm_en) run_cnt++;
    if (done != 2'b00 || tout != 2'b00) last_run_len = run_cnt;
    if (done[0]) done_cnt0++;
    if (done[1]) done_cnt1++;
    if (tout[0]) tout_cnt0++;
    if (tout[1]) tout_cnt1++;
    prev_gnt = gnt;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input string name);
    int k;
    k = 0;
    while (!fsm_en && k < 20) begin
      tick(1);
      k++;
    end
    check(name, fsm_en, 1'b1);
  endtask

  task automatic finish_job();
    fsm_finish = 1'b1;
    tick(1);
    fsm_finish = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d1, t0, t1, k;
    // reset state
    tick(3);
    check("rst_gnt", gnt, 2'b00);
    check("rst_fsm_rst", fsm_rst, 1'b1);
    check("rst_stop_cnt", stop_cnt, 8'd0);
    check("rst_fsm_en", fsm_en, 1'b0);
    rst_n = 1'b1;
    tick(1);
    check("idle_fsm_rst", fsm_rst, 1'b0);

    // single request, requester 0, ls=0 rs=1
    req = 2'b01; req_ls = 2'b00; req_rs = 2'b01;
    tick(1);
    check("t1_gnt", gnt, 2'b01);
    check("t1_kick", fsm_rst, 1'b1);
    check("t1_kick_en", fsm_en, 1'b0);
    tick(1);
    check("t1_kick_end", fsm_rst, 1'b0);
    check("t1_en", fsm_en, 1'b1);
    check("t1_ls", fsm_ls, 1'b0);
    check("t1_rs", fsm_rs, 1'b1);
    tick(2);
    finish_job();
    check("t1_done", done, 2'b01);
    check("t1_done_gnt", gnt, 2'b01);
    req = 2'b00;
    tick(1);
    check("t1_idle_gnt", gnt, 2'b00);
    check("t1_idle_done", done, 2'b00);

    // round robin from a fresh reset
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    got_gnt.delete();
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    d0 = done_cnt0; d1 = done_cnt1;
    req = 2'b11; req_ls = 2'b10; req_rs = 2'b01;
    for (int j = 0; j < 4; j++) begin
      wait_en("t2_start");
      tick(1);
      finish_job();
    end
    req = 2'b00;
    tick(2);
    check("t2_jobs", got_gnt.size(), 4);
    for (int j = 0; j < 4 && j < got_gnt.size(); j++) check("t2_gnt_seq", got_gnt[j], exp_q[j]);
    check("t2_done0", done_cnt0 - d0, 2);
    check("t2_done1", done_cnt1 - d1, 2);

    // timeout, requester 0, fsm_finish never set
    d0 = done_cnt0 + done_cnt1; t0 = tout_cnt0;
    req = 2'b01;
    wait_en("t3_start");
    k = 0;
    while (tout == 2'b00 && k < 20) begin
      fsm_busy = ~fsm_busy;
      tick(1);
      k++;
    end
    check("t3_tout", tout, 2'b01);
    req = 2'b00;
    tick(2);
    check("t3_tout_cnt", tout_cnt0 - t0, 1);
    check("t3_no_done", done_cnt0 + done_cnt1 - d0, 0);
    check("t3_run_len", last_run_len, TIMEOUT + 1);

    // finish coincides with timer==TIMEOUT
    t1 = tout_cnt0 + tout_cnt1;
    req = 2'b10;
    wait_en("t4_start");
    tick(TIMEOUT);
    finish_job();
    check("t4_done", done, 2'b10);
    check("t4_tout", tout, 2'b00);
    req = 2'b00;
    tick(2);
    check("t4_no_tout", tout_cnt0 + tout_cnt1 - t1, 0);
    check("t4_run_len", last_run_len, TIMEOUT + 1);

    // abort by requester 1 on run cycle 3, requester 0 pending
    d0 = done_cnt0 + done_cnt1; t0 = tout_cnt0 + tout_cnt1;
    req = 2'b10;
    wait_en("t5_start");
    req = 2'b11;
    tick(3);
    req = 2'b01;
    tick(1);
    check("t5_abort_gnt", gnt, 2'b00);
    check("t5_abort_en", fsm_en, 1'b0);
    check("t5_no_pulse", done_cnt0 + done_cnt1 + tout_cnt0 + tout_cnt1 - d0 - t0, 0);
    tick(1);
    check("t5_regrant", gnt, 2'b01);
    wait_en("t5_restart");
    tick(1);
    finish_job();
    check("t5_done", done, 2'b01);
    req = 2'b00;
    tick(2);

    // asynchronous reset in the middle of a run
    req = 2'b01;
    wait_en("t6_start");
    fsm_stop = 1'b1;
    tick(2);
    fsm_stop = 1'b0;
    check("t6_stop_pre", stop_cnt, 8'd2);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_gnt", gnt, 2'b00);
    check("t6_async_stop", stop_cnt, 8'd0);
    check("t6_async_fsm_rst", fsm_rst, 1'b1);
    check("t6_async_en", fsm_en, 1'b0);
    check("t6_async_state", state, 2'd0);
    req = 2'b00;
    tick(2);
    rst_n = 1'b1;
    req = 2'b01;
    tick(1);
    check("t6_kick", fsm_rst, 1'b1);
    check("t6_stop_clear", stop_cnt, 8'd0);
    wait_en("t6_restart");

    // two stop cycles within one job
    fsm_stop = 1'b1;
    tick(1);
    fsm_stop = 1'b0;
    tick(1);
    fsm_stop = 1'b1;
    tick(1);
    fsm_stop = 1'b0;
    finish_job();
    check("t7_done", done, 2'b01);
    check("t7_stop_cnt", stop_cnt, 8'd2);
    req = 2'b00;
    tick(2);
    check("t7_stop_hold", stop_cnt, 8'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
